fft_iter_frame_loader: RTL and testbench

Frame scheduler in front of the iterative FFT core. Accepts a valid/ready sample stream and packs sample pairs into the core's input dual-port RAM through its two write ports, in bit-reversed order when enabled. Once a full frame of 2^AWL samples is written, issues a one-cycle START. It then tracks the core's RAM-block (FIRST) indication to know when the input RAM is released, and holds the upstream source until the next frame may be loaded.

---
 rtl/fft_iter_frame_loader.sv | 146 ++++++++++++++
 tb/tb_fft_iter_frame_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_iter_frame_loader.sv
// Packs a valid/ready sample stream into the FFT core's dual-port input RAM as sample pairs,
// optionally bit-reversed, then sequences START and the core's RAM-block handshake.
module fft_iter_frame_loader #(
  parameter int unsigned IWL      = 32,
  parameter int unsigned AWL      = 5,
  parameter int unsigned BITREV   = 1,
  parameter int unsigned START_TO = 16
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           EN,
  input  logic [IWL-1:0] i_S_DATA,
  input  logic           i_S_VALID,
  output logic           o_S_READY,
  output logic [IWL-1:0] o_A_DATA,
  output logic [IWL-1:0] o_B_DATA,
  output logic [IWL-1:0] o_A_ADDR,
  output logic [IWL-1:0] o_B_ADDR,
  output logic           o_RAM_Wr,
  output logic           o_START,
  input  logic           i_RAM_BLOCK,
  output logic           o_BUSY,
  output logic           o_FRAME_DONE,
  output logic [7:0]     o_FRAME_CNT,
  output logic           o_ERR
);

  localparam int unsigned TW   = $clog2(START_TO + 1);
  localparam int unsigned PADW = IWL - AWL;
  localparam logic [TW-1:0] TO_LAST = TW'(START_TO - 1);

  typedef enum logic [2:0] {StLoad, StFlush, StStart, StWaitBlk, StRun} state_e;

  state_e         state_q;
  logic [AWL-1:0] n_q;
  logic [IWL-1:0] hold_q;
  logic           wr_q;
  logic           blk_q;
  logic           done_q;
  logic [TW-1:0]  to_q;
  logic [7:0]     cnt_q;
  logic           err_q;
  logic [IWL-1:0] a_data_q, b_data_q, a_addr_q, b_addr_q;

  logic xfer;
  logic wr_fire;

  function automatic logic [AWL-1:0] map_addr(input logic [AWL-1:0] a);
    logic [AWL-1:0] r;
    for (int i = 0; i < AWL; i++) begin
      r[i] = (BITREV != 0) ? a[AWL-1-i] : a[i];
    end
    return r;
  endfunction

  // Ready is combinational so a stream can be taken every cycle; RST forces it low.
  assign o_S_READY = ~RST & EN & ~i_RAM_BLOCK & (state_q == StLoad);
  assign xfer      = i_S_VALID & o_S_READY;
  // A pending pair write waits out EN low or a core RAM block instead of being dropped.
  assign wr_fire   = wr_q & EN & ~i_RAM_BLOCK;

  assign o_RAM_Wr     = wr_fire;
  assign o_START      = EN & (state_q == StStart);
  assign o_FRAME_DONE = EN & done_q;
  assign o_BUSY       = (state_q != StLoad);
  assign o_FRAME_CNT  = cnt_q;
  assign o_ERR        = err_q;
  assign o_A_DATA     = a_data_q;
  assign o_B_DATA     = b_data_q;
  assign o_A_ADDR     = a_addr_q;
  assign o_B_ADDR     = b_addr_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= StLoad;
      n_q      <= '0;
      hold_q   <= '0;
      wr_q     <= 1'b0;
      blk_q    <= 1'b0;
      done_q   <= 1'b0;
      to_q     <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      a_data_q <= '0;
      b_data_q <= '0;
      a_addr_q <= '0;
      b_addr_q <= '0;
    end else if (EN) begin
      blk_q  <= i_RAM_BLOCK;
      done_q <= 1'b0;
      if (wr_fire) begin
        wr_q <= 1'b0;
      end
      if (xfer) begin
        n_q <= n_q + 1'b1;
        if (!n_q[0]) begin
          hold_q <= i_S_DATA;
        end else begin
          wr_q     <= 1'b1;
          a_data_q <= hold_q;
          b_data_q <= i_S_DATA;
          a_addr_q <= {{PADW{1'b0}}, map_addr({n_q[AWL-1:1], 1'b0})};
          b_addr_q <= {{PADW{1'b0}}, map_addr(n_q)};
        end
      end
      unique case (state_q)
        StLoad: begin
          if (xfer && (&n_q)) begin
            state_q <= StFlush;
          end
        end
        StFlush: begin
          if (!i_RAM_BLOCK) begin
            state_q <= StStart;
          end
        end
        StStart: begin
          to_q    <= '0;
          state_q <= StWaitBlk;
        end
        StWaitBlk: begin
          if (i_RAM_BLOCK) begin
            state_q <= StRun;
          end else if (to_q == TO_LAST) begin
            err_q   <= 1'b1;
            n_q     <= '0;
            state_q <= StLoad;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        StRun: begin
          // Fall is judged against the last enabled-cycle sample of the block flag.
          if (blk_q && !i_RAM_BLOCK) begin
            done_q  <= 1'b1;
            cnt_q   <= cnt_q + 8'd1;
            n_q     <= '0;
            state_q <= StLoad;
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_iter_frame_loader.sv
// Directed bench for fft_iter_frame_loader: reset, full frames, gaps/EN stalls, timeout,
// handshake with EN/fall collision, and reset during RUN.
module tb_fft_iter_frame_loader;

  logic        CLK = 1'b0;
  logic        RST, EN, i_S_VALID, i_RAM_BLOCK;
  logic [31:0] i_S_DATA;
  logic        o_S_READY, o_RAM_Wr, o_START, o_BUSY, o_FRAME_DONE, o_ERR;
  logic [31:0] o_A_DATA, o_B_DATA, o_A_ADDR, o_B_ADDR;
  logic [7:0]  o_FRAME_CNT;

  int checks = 0;
  int errors = 0;

  logic [31:0] la [32];
  logic [31:0] lb [32];
  logic [31:0] lda [32];
  logic [31:0] ldb [32];
  int wn = 0;

  always #5 CLK = ~CLK;

  fft_iter_frame_loader #(
    .IWL     (32),
    .AWL     (5),
    .BITREV  (1),
    .START_TO(16)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .EN          (EN),
    .i_S_DATA    (i_S_DATA),
    .i_S_VALID   (i_S_VALID),
    .o_S_READY   (o_S_READY),
    .o_A_DATA    (o_A_DATA),
    .o_B_DATA    (o_B_DATA),
    .o_A_ADDR    (o_A_ADDR),
    .o_B_ADDR    (o_B_ADDR),
    .o_RAM_Wr    (o_RAM_Wr),
    .o_START     (o_START),
    .i_RAM_BLOCK (i_RAM_BLOCK),
    .o_BUSY      (o_BUSY),
    .o_FRAME_DONE(o_FRAME_DONE),
    .o_FRAME_CNT (o_FRAME_CNT),
    .o_ERR       (o_ERR)
  );

  // Write log, sampled mid-cycle.
  always @(negedge CLK) begin
    if (o_RAM_Wr === 1'b1) begin
      if (wn < 32) begin
        la[wn]  = o_A_ADDR;
        lb[wn]  = o_B_ADDR;
        lda[wn] = o_A_DATA;
        ldb[wn] = o_B_DATA;
      end
      wn++;
    end
  end

  function automatic logic [4:0] brev5(input logic [4:0] x);
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  // Frame of samples 0..31 must land as 16 bit-reversed pairs.
  task automatic check_frame(input string pfx);
    logic [4:0] e;
    chk({pfx, "_nwrites"}, 32'(wn), 32'd16);
    for (int k = 0; k < 16; k++) begin
      e = brev5(5'(2 * k));
      chk($sformatf("%s_a_addr%0d", pfx, k), la[k], {27'd0, e});
      chk($sformatf("%s_b_addr%0d", pfx, k), lb[k], 32'(e) + 32'd16);
      chk($sformatf("%s_a_data%0d", pfx, k), lda[k], 32'(2 * k));
      chk($sformatf("%s_b_data%0d", pfx, k), ldb[k], 32'(2 * k + 1));
    end
  endtask

  initial begin
    int bad;
    int seen;

    // Reset with valid asserted
    RST = 1'b1; EN = 1'b1; i_S_VALID = 1'b1; i_S_DATA = 32'h1234; i_RAM_BLOCK = 1'b0;
    smp();
    chk("rst_ready", 32'(o_S_READY), 32'd0);
    chk("rst_wr", 32'(o_RAM_Wr), 32'd0);
    chk("rst_start", 32'(o_START), 32'd0);
    chk("rst_busy", 32'(o_BUSY), 32'd0);
    chk("rst_done", 32'(o_FRAME_DONE), 32'd0);
    chk("rst_err", 32'(o_ERR), 32'd0);
    chk("rst_cnt", 32'(o_FRAME_CNT), 32'd0);
    chk("rst_a_addr", o_A_ADDR, 32'd0);
    adv(); RST = 1'b0; i_S_VALID = 1'b0;
    smp();
    chk("post_rst_ready", 32'(o_S_READY), 32'd1);
    chk("post_rst_cnt", 32'(o_FRAME_CNT), 32'd0);

    // Back-to-back full frame
    wn = 0; bad = 0;
    for (int i = 0; i < 32; i++) begin
      adv(); i_S_VALID = 1'b1; i_S_DATA = 32'(i);
      smp();
      if (o_S_READY !== 1'b1) bad++;
    end
    chk("b2b_ready", 32'(bad), 32'd0);
    adv(); i_S_VALID = 1'b0;
    smp();
    chk("flush_wr", 32'(o_RAM_Wr), 32'd1);
    chk("flush_start", 32'(o_START), 32'd0);
    chk("flush_ready", 32'(o_S_READY), 32'd0);
    chk("flush_busy", 32'(o_BUSY), 32'd1);
    adv(); smp();
    chk("start_pulse", 32'(o_START), 32'd1);
    chk("start_wr", 32'(o_RAM_Wr), 32'd0);
    check_frame("b2b");
    chk("b2b_pair0_b_addr", lb[0], 32'd16);
    chk("b2b_pair1_a_addr", la[1], 32'd8);

    // Handshake: block rises 3 cycles after START, EN drop collides with the fall
    adv(); smp();
    chk("start_one_cycle", 32'(o_START), 32'd0);
    adv(); smp();
    adv(); i_RAM_BLOCK = 1'b1; smp();
    chk("blk_busy", 32'(o_BUSY), 32'd1);
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      adv(); smp();
      if (o_S_READY !== 1'b0 || o_FRAME_DONE !== 1'b0 || o_RAM_Wr !== 1'b0 || o_BUSY !== 1'b1)
        bad++;
    end
    chk("run_quiet", 32'(bad), 32'd0);
    adv(); i_RAM_BLOCK = 1'b0; EN = 1'b0; smp();
    chk("fall_en_low_done", 32'(o_FRAME_DONE), 32'd0);
    adv(); smp();
    chk("en_low_ready", 32'(o_S_READY), 32'd0);
    adv(); EN = 1'b1; smp();
    chk("en_back_done", 32'(o_FRAME_DONE), 32'd0);
    chk("en_back_busy", 32'(o_BUSY), 32'd1);
    adv(); smp();
    chk("done_pulse", 32'(o_FRAME_DONE), 32'd1);
    chk("done_cnt", 32'(o_FRAME_CNT), 32'd1);
    chk("done_ready", 32'(o_S_READY), 32'd1);
    chk("done_busy", 32'(o_BUSY), 32'd0);
    adv(); smp();
    chk("done_one_cycle", 32'(o_FRAME_DONE), 32'd0);

    // Frame with valid gaps and an EN stall right after an odd accept
    wn = 0; bad = 0;
    for (int i = 0; i < 32; i++) begin
      adv(); EN = 1'b1; i_S_VALID = 1'b1; i_S_DATA = 32'(i);
      smp();
      if (o_S_READY !== 1'b1) bad++;
      if (i % 2 == 0) begin
        for (int g = 0; g < 2; g++) begin
          adv(); i_S_VALID = 1'b0; i_S_DATA = 32'hDEADBEEF; smp();
        end
      end
      if (i == 11) begin
        for (int g = 0; g < 5; g++) begin
          adv(); EN = 1'b0; i_S_VALID = 1'b1; i_S_DATA = 32'hBADC0DE5; smp();
          if (o_RAM_Wr !== 1'b0 || o_S_READY !== 1'b0) bad++;
        end
      end
    end
    chk("gap_ready_and_en_quiet", 32'(bad), 32'd0);
    seen = 0;
    for (int c = 0; c < 6 && seen == 0; c++) begin
      adv(); i_S_VALID = 1'b0; smp();
      if (o_START === 1'b1) seen = 1;
    end
    chk("gap_start_seen", 32'(seen), 32'd1);
    check_frame("gap");

    // Timeout: block never rises
    for (int c = 0; c < 15; c++) begin
      adv(); smp();
    end
    adv(); smp();
    chk("to_err_early", 32'(o_ERR), 32'd0);
    chk("to_busy_early", 32'(o_BUSY), 32'd1);
    adv(); smp();
    chk("to_err", 32'(o_ERR), 32'd1);
    chk("to_busy", 32'(o_BUSY), 32'd0);
    chk("to_ready", 32'(o_S_READY), 32'd1);
    chk("to_cnt", 32'(o_FRAME_CNT), 32'd1);
    adv(); i_S_VALID = 1'b1; i_S_DATA = 32'h000000A5; smp();
    adv(); i_S_DATA = 32'h0000005A; smp();
    adv(); i_S_VALID = 1'b0; smp();
    chk("to_pair0_wr", 32'(o_RAM_Wr), 32'd1);
    chk("to_pair0_a_addr", o_A_ADDR, 32'd0);
    chk("to_pair0_b_addr", o_B_ADDR, 32'd16);
    chk("to_pair0_a_data", o_A_DATA, 32'h000000A5);
    chk("to_pair0_b_data", o_B_DATA, 32'h0000005A);

    // Finish that frame, enter RUN, then reset
    for (int i = 2; i < 32; i++) begin
      adv(); i_S_VALID = 1'b1; i_S_DATA = 32'(i); smp();
    end
    seen = 0;
    for (int c = 0; c < 6 && seen == 0; c++) begin
      adv(); i_S_VALID = 1'b0; smp();
      if (o_START === 1'b1) seen = 1;
    end
    chk("rr_start_seen", 32'(seen), 32'd1);
    adv(); i_RAM_BLOCK = 1'b1; smp();
    adv(); smp();
    chk("rr_busy", 32'(o_BUSY), 32'd1);
    chk("rr_err_before", 32'(o_ERR), 32'd1);
    chk("rr_cnt_before", 32'(o_FRAME_CNT), 32'd1);
    adv(); RST = 1'b1; #1;
    chk("rr_busy_now", 32'(o_BUSY), 32'd0);
    chk("rr_cnt_now", 32'(o_FRAME_CNT), 32'd0);
    chk("rr_err_now", 32'(o_ERR), 32'd0);
    chk("rr_wr_now", 32'(o_RAM_Wr), 32'd0);
    smp();
    adv(); RST = 1'b0; smp();
    chk("rr_blocked_ready", 32'(o_S_READY), 32'd0);
    adv(); i_RAM_BLOCK = 1'b0; smp();
    chk("rr_ready", 32'(o_S_READY), 32'd1);
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      adv(); smp();
      if (o_FRAME_DONE !== 1'b0 || o_FRAME_CNT !== 8'd0) bad++;
    end
    chk("rr_no_done", 32'(bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
